tim_apb_cfg_seq: RTL and testbench

APB master that programs the advanced timer (apoip_timer) from a small on-chip table of {address, data} entries. Software or a boot FSM loads the table, then pulses start; the block issues the writes in order using APB SETUP/ACCESS phases. Typical table: ARR, CCMRx, CCER, SMCR, then CR1 last so the counter is enabled only after it is configured. Sits between the system configuration master and the timer's APB slave port.

---
 rtl/tim_cfg_pkg.sv | 38 +++
 rtl/tim_cfg_tbl.sv | 43 ++++
 rtl/tim_apb_cfg_seq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_tim_apb_cfg_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tim_cfg_pkg.sv
// ----------------------------------------------------------------------------
// tim_cfg_pkg
// Shared types and constants for the timer APB configuration sequencer:
//   - tim_cfg_state_e : sequencer FSM states (read states used only when
//                       TIM_CFG_SEQ_VERIFY_EN is defined)
//   - tim_cfg_entry_t : one table entry {addr[15:0], data[31:0]}
//   - TIM_*           : apoip_timer APB register offsets
//   - VERIFY_SKIP_BIT : address bit that marks an entry as write-only
// ----------------------------------------------------------------------------
package tim_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_DONE    = 3'd3,
        ST_RSETUP  = 3'd4,
        ST_RACCESS = 3'd5
    } tim_cfg_state_e;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } tim_cfg_entry_t;

    localparam logic [ADDR_W-1:0] TIM_CR1   = 16'h0000;
    localparam logic [ADDR_W-1:0] TIM_SMCR  = 16'h0008;
    localparam logic [ADDR_W-1:0] TIM_CCMR1 = 16'h0018;
    localparam logic [ADDR_W-1:0] TIM_CCER  = 16'h0020;
    localparam logic [ADDR_W-1:0] TIM_ARR   = 16'h002C;

    localparam int unsigned VERIFY_SKIP_BIT = 15;

endpackage

// File: rtl/tim_cfg_tbl.sv
// ----------------------------------------------------------------------------
// tim_cfg_tbl
// DEPTH x 48-bit entry table: synchronous write port, asynchronous read port.
// Contents clear on reset.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en_i      : write strobe (already qualified by the caller)
//   wr_idx_i     : write index
//   wr_entry_i   : entry to store
//   rd_idx_i     : read index
//   rd_entry_o   : entry at rd_idx_i (combinational)
// ----------------------------------------------------------------------------
module tim_cfg_tbl
    import tim_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  tim_cfg_entry_t       wr_entry_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output tim_cfg_entry_t       rd_entry_o
);

    tim_cfg_entry_t mem_q [DEPTH];

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_entry_i;
        end
    end

    assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/tim_apb_cfg_seq.sv
// ----------------------------------------------------------------------------
// tim_apb_cfg_seq
// APB master that replays a table of {address, data} writes into the
// apoip_timer register block, in table order, after a start pulse.
// Optional macro TIM_CFG_SEQ_VERIFY_EN: read back each written address
// (unless addr bit 15 is set) and flag a data mismatch as an error.
// Ports:
//   apb_clk, apb_rst_n       : clock, asynchronous active-low reset
//   tbl_wr_en/idx/addr/data  : table load port (accepted only when idle)
//   seq_start, seq_len       : start pulse and entry count (clamped to DEPTH)
//   seq_abort                : finish after the transfer in flight
//   seq_busy, seq_done       : run in progress, one-cycle completion pulse
//   seq_err, seq_err_idx     : sticky error flag and failing entry index
//   seq_cnt                  : entries completed in current/last run
//   m_p*                     : APB master interface
// ----------------------------------------------------------------------------
module tim_apb_cfg_seq
    import tim_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                 apb_clk,
    input  logic                 apb_rst_n,
    input  logic                 tbl_wr_en,
    input  logic [IDX_W-1:0]     tbl_wr_idx,
    input  logic [15:0]          tbl_wr_addr,
    input  logic [31:0]          tbl_wr_data,
    input  logic                 seq_start,
    input  logic [IDX_W:0]       seq_len,
    input  logic                 seq_abort,
    output logic                 seq_busy,
    output logic                 seq_done,
    output logic                 seq_err,
    output logic [IDX_W-1:0]     seq_err_idx,
    output logic [IDX_W:0]       seq_cnt,
    output logic                 m_psel,
    output logic                 m_penable,
    output logic                 m_pwrite,
    output logic [15:0]          m_paddr,
    output logic [31:0]          m_pwdata,
    input  logic [31:0]          m_prdata,
    input  logic                 m_pready,
    input  logic                 m_pslverr
);

    localparam int unsigned LEN_W = IDX_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    tim_cfg_state_e      state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    err_idx_q, err_idx_d;
    logic                abort_q, abort_d;

    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [15:0]         paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tbl_we_c;
    tim_cfg_entry_t      wr_entry_c;
    tim_cfg_entry_t      rd_raw_c;
    tim_cfg_entry_t      rd_entry_c;
    logic                last_c;
    logic                abort_eff_c;

    // Table is frozen for the whole run
    assign tbl_we_c   = tbl_wr_en && (state_q == ST_IDLE);
    assign wr_entry_c = '{addr: tbl_wr_addr, data: tbl_wr_data};

    tim_cfg_tbl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_tbl (
        .clk        (apb_clk),
        .rst_n      (apb_rst_n),
        .wr_en_i    (tbl_we_c),
        .wr_idx_i   (tbl_wr_idx),
        .wr_entry_i (wr_entry_c),
        .rd_idx_i   (idx_d),
        .rd_entry_o (rd_raw_c)
    );

    // Forward a same-cycle write so a start issued with a load sees the new entry
    assign rd_entry_c = (tbl_we_c && (tbl_wr_idx == idx_d)) ? wr_entry_c : rd_raw_c;

    assign last_c      = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    assign abort_eff_c = abort_q || seq_abort;

`ifndef TIM_CFG_SEQ_VERIFY_EN
    logic unused_prdata;
    assign unused_prdata = ^m_prdata;
`endif

    // State register
    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and run bookkeeping
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        abort_d   = abort_q;
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (seq_start) begin
                    len_d     = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    idx_d     = '0;
                    state_d   = (len_d == '0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                abort_d = abort_eff_c;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                abort_d = abort_eff_c;
                if (m_pready) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (m_pslverr) begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = ST_DONE;
                    end
`ifdef TIM_CFG_SEQ_VERIFY_EN
                    else if (!paddr_q[VERIFY_SKIP_BIT]) begin
                        state_d = ST_RSETUP;
                    end
`endif
                    else if (last_c || abort_eff_c) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SETUP;
                    end
                end
            end
`ifdef TIM_CFG_SEQ_VERIFY_EN
            ST_RSETUP: begin
                abort_d = abort_eff_c;
                state_d = ST_RACCESS;
            end
            ST_RACCESS: begin
                abort_d = abort_eff_c;
                if (m_pready) begin
                    if (m_pslverr || (m_prdata != pwdata_q)) begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = ST_DONE;
                    end else if (last_c || abort_eff_c) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SETUP;
                    end
                end
            end
`endif
            ST_DONE: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the APB pins are registered
    always_comb begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        case (state_d)
            ST_SETUP: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = rd_entry_c.addr;
                pwdata_d = rd_entry_c.data;
            end
            ST_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_RSETUP: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b0;
            end
            ST_RACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            abort_q   <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            abort_q   <= abort_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign seq_busy    = busy_q;
    assign seq_done    = done_q;
    assign seq_err     = err_q;
    assign seq_err_idx = err_idx_q;
    assign seq_cnt     = cnt_q;
    assign m_psel      = psel_q;
    assign m_penable   = penable_q;
    assign m_pwrite    = pwrite_q;
    assign m_paddr     = paddr_q;
    assign m_pwdata    = pwdata_q;

endmodule

// File: tb/tb_tim_apb_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_tim_apb_cfg_seq
// Self-checking bench for tim_apb_cfg_seq (default build, DEPTH=8).
// ----------------------------------------------------------------------------
module tb_tim_apb_cfg_seq;
    import tim_cfg_pkg::*;

    localparam int unsigned IDX_W = 3;

    logic              apb_clk = 1'b0;
    logic              apb_rst_n = 1'b0;
    logic              tbl_wr_en = 1'b0;
    logic [IDX_W-1:0]  tbl_wr_idx = '0;
    logic [15:0]       tbl_wr_addr = '0;
    logic [31:0]       tbl_wr_data = '0;
    logic              seq_start = 1'b0;
    logic [IDX_W:0]    seq_len = '0;
    logic              seq_abort = 1'b0;
    logic              seq_busy, seq_done, seq_err;
    logic [IDX_W-1:0]  seq_err_idx;
    logic [IDX_W:0]    seq_cnt;
    logic              m_psel, m_penable, m_pwrite;
    logic [15:0]       m_paddr;
    logic [31:0]       m_pwdata;
    logic [31:0]       m_prdata = '0;
    logic              m_pready;
    logic              m_pslverr;

    always #5 apb_clk = ~apb_clk;

    tim_apb_cfg_seq #(.DEPTH(8), .IDX_W(IDX_W)) dut (
        .apb_clk     (apb_clk),
        .apb_rst_n   (apb_rst_n),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_idx  (tbl_wr_idx),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_wr_data (tbl_wr_data),
        .seq_start   (seq_start),
        .seq_len     (seq_len),
        .seq_abort   (seq_abort),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .seq_err     (seq_err),
        .seq_err_idx (seq_err_idx),
        .seq_cnt     (seq_cnt),
        .m_psel      (m_psel),
        .m_penable   (m_penable),
        .m_pwrite    (m_pwrite),
        .m_paddr     (m_paddr),
        .m_pwdata    (m_pwdata),
        .m_prdata    (m_prdata),
        .m_pready    (m_pready),
        .m_pslverr   (m_pslverr)
    );

    typedef struct {
        int len;
        int wait_ent;
        int waits;
        int err_ent;
        int abort_cyc;
        int poke_cyc;
        int exp_cnt;
        int exp_err;
        int exp_eidx;
        int exp_lat;
    } vec_t;

    int errors = 0;
    int checks = 0;

    tim_cfg_entry_t tb_tbl [8];
    tim_cfg_entry_t sb [$];
    tim_cfg_entry_t mon_e;

    // slave model state
    int wait_ent = -1;
    int waits    = 0;
    int err_ent  = -1;
    int run_base = 0;
    int cur_ent  = 0;
    int wcnt     = 0;
    int xfer_tot = 0;
    int psel_tot = 0;
    logic [15:0] setup_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: wait states and error on a chosen entry of the current run
    always @(posedge apb_clk) begin
        if (m_psel && !m_penable) begin
            cur_ent <= xfer_tot - run_base;
            wcnt    <= ((xfer_tot - run_base) == wait_ent) ? waits : 0;
        end else if (m_psel && m_penable && wcnt != 0) begin
            wcnt <= wcnt - 1;
        end
    end
    assign m_pready  = (wcnt == 0);
    assign m_pslverr = m_psel && m_penable && (cur_ent == err_ent);

    // Monitor: protocol checks and scoreboard pop on each completed transfer
    always @(negedge apb_clk) begin
        if (apb_rst_n) begin
            if (m_psel) psel_tot++;
            if (m_psel && !m_penable) begin
                check("setup_pwrite", 64'(m_pwrite), 64'(1));
                setup_addr = m_paddr;
            end
            if (m_psel && m_penable) begin
                check("hold_paddr", 64'(m_paddr), 64'(setup_addr));
                if (m_pready) begin
                    xfer_tot++;
                    if (sb.size() == 0) begin
                        check("unexpected_xfer_addr", 64'(m_paddr), 64'hFFFF_FFFF);
                    end else begin
                        mon_e = sb.pop_front();
                        check("xfer_addr", 64'(m_paddr), 64'(mon_e.addr));
                        check("xfer_data", 64'(m_pwdata), 64'(mon_e.data));
                    end
                end
            end
        end
    end

    task automatic load(input int idx, input logic [15:0] a, input logic [31:0] d);
        tbl_wr_en   = 1'b1;
        tbl_wr_idx  = IDX_W'(idx);
        tbl_wr_addr = a;
        tbl_wr_data = d;
        @(posedge apb_clk); #1;
        tbl_wr_en   = 1'b0;
        tb_tbl[idx] = '{addr: a, data: d};
    endtask

    // Apply one vector; co_wr loads entry 0 in the same cycle as start
    task automatic run(input vec_t v, input bit co_wr, input logic [15:0] co_a, input logic [31:0] co_d);
        int lat;
        int psel0;
        int exp_psel;
        run_base = xfer_tot;
        psel0    = psel_tot;
        wait_ent = v.wait_ent;
        waits    = v.waits;
        err_ent  = v.err_ent;
        if (co_wr) tb_tbl[0] = '{addr: co_a, data: co_d};
        sb.delete();
        for (int k = 0; k < v.exp_cnt; k++) sb.push_back(tb_tbl[k]);
        seq_len   = (IDX_W+1)'(v.len);
        seq_start = 1'b1;
        if (co_wr) begin
            tbl_wr_en = 1'b1; tbl_wr_idx = '0; tbl_wr_addr = co_a; tbl_wr_data = co_d;
        end
        @(posedge apb_clk); #1;
        seq_start = 1'b0;
        tbl_wr_en = 1'b0;
        lat = 1;
        while (!seq_done && lat < 200) begin
            seq_abort = (lat == v.abort_cyc);
            if (lat == v.poke_cyc) begin
                seq_start = 1'b1; seq_len = 4'd2;
                tbl_wr_en = 1'b1; tbl_wr_idx = 3'd4; tbl_wr_addr = 16'h0030; tbl_wr_data = 32'hDEAD;
            end else begin
                seq_start = 1'b0;
                tbl_wr_en = 1'b0;
            end
            @(posedge apb_clk); #1;
            lat++;
        end
        seq_abort = 1'b0;
        seq_start = 1'b0;
        tbl_wr_en = 1'b0;
        check("done_within_budget", 64'(seq_done), 64'(1));
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("seq_cnt", 64'(seq_cnt), 64'(v.exp_cnt));
        check("seq_err", 64'(seq_err), 64'(v.exp_err));
        check("seq_err_idx", 64'(seq_err_idx), 64'(v.exp_eidx));
        check("busy_at_done", 64'(seq_busy), 64'(1));
        check("done_psel", 64'(m_psel), 64'(0));
        check("sb_drained", 64'(sb.size()), 64'(0));
        exp_psel = 2 * v.exp_cnt + ((v.wait_ent >= 0 && v.wait_ent < v.exp_cnt) ? v.waits : 0);
        check("psel_cycles", 64'(psel_tot - psel0), 64'(exp_psel));
        @(posedge apb_clk); #1;
        check("done_pulse_1cyc", 64'(seq_done), 64'(0));
        check("idle_busy", 64'(seq_busy), 64'(0));
        @(posedge apb_clk); #1;
    endtask

    vec_t vecs [7];
    vec_t v1;

    initial begin
        //            len wE wN eE ab pk cnt err eidx lat
        vecs[0] = '{5, -1, 0, -1, 0, 0, 5, 0, 0, 11};  // basic 5-entry run
        vecs[1] = '{5,  2, 3, -1, 0, 0, 5, 0, 0, 14};  // 3 wait states on entry 2
        vecs[2] = '{5, -1, 0,  3, 0, 0, 4, 1, 3,  9};  // slave error on entry 3
        vecs[3] = '{0, -1, 0, -1, 0, 0, 0, 0, 0,  1};  // len=0
        vecs[4] = '{12,-1, 0, -1, 0, 0, 8, 0, 0, 17};  // len clamped to DEPTH
        vecs[5] = '{5, -1, 0, -1, 3, 0, 2, 0, 0,  5};  // abort in SETUP of entry 1
        vecs[6] = '{5, -1, 0, -1, 0, 4, 5, 0, 0, 11};  // start/table write while busy

        // reset state
        #12;
        check("rst_psel", 64'(m_psel), 64'(0));
        check("rst_penable", 64'(m_penable), 64'(0));
        check("rst_pwrite", 64'(m_pwrite), 64'(0));
        check("rst_paddr", 64'(m_paddr), 64'(0));
        check("rst_pwdata", 64'(m_pwdata), 64'(0));
        check("rst_busy", 64'(seq_busy), 64'(0));
        check("rst_done", 64'(seq_done), 64'(0));
        check("rst_err", 64'(seq_err), 64'(0));
        check("rst_cnt", 64'(seq_cnt), 64'(0));
        @(posedge apb_clk); #1;
        apb_rst_n = 1'b1;
        @(posedge apb_clk); #1;

        load(0, TIM_ARR,   32'd6);
        load(1, TIM_CCMR1, 32'd100);
        load(2, TIM_CCER,  32'd0);
        load(3, TIM_SMCR,  32'd67);
        load(4, TIM_CR1,   32'd25);
        load(5, 16'h0004,  32'h11);
        load(6, 16'h0010,  32'h22);
        load(7, 16'h0024,  32'h33);

        for (int i = 0; i < 7; i++) run(vecs[i], 1'b0, '0, '0);

        // table write together with start: the run must use the new entry 0
        v1 = '{1, -1, 0, -1, 0, 0, 1, 0, 0, 3};
        run(v1, 1'b1, 16'h0028, 32'h1234_5678);

        // reset in the middle of entry 1's ACCESS
        run_base = xfer_tot;
        wait_ent = -1; err_ent = -1;
        sb.delete();
        sb.push_back(tb_tbl[0]);
        seq_len = 4'd5;
        seq_start = 1'b1;
        @(posedge apb_clk); #1;
        seq_start = 1'b0;
        repeat (3) begin
            @(posedge apb_clk); #1;
        end
        check("mid_access_before_rst", 64'({m_psel, m_penable}), 64'(3));
        apb_rst_n = 1'b0;
        #1;
        check("rst_async_psel", 64'(m_psel), 64'(0));
        check("rst_async_penable", 64'(m_penable), 64'(0));
        check("rst_async_busy", 64'(seq_busy), 64'(0));
        check("rst_sb_entry0_seen", 64'(sb.size()), 64'(0));
        @(posedge apb_clk); #1;
        apb_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tb_tbl[k] = '0;
        @(posedge apb_clk); #1;
        v1 = '{1, -1, 0, -1, 0, 0, 1, 0, 0, 3};
        run(v1, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
